// File: rtl/pipeline_fetch.sv
// rtl/pipeline_fetch.sv - fetch stage: owns the PC, issues one imem request at a time, feeds the FD register
module pipeline_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h00400000,
  parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_f,
  input  logic        pc_src_d,
  input  logic [31:0] pc_branch_d,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_f,
  output logic [31:0] pc_plus_4_f,
  output logic        fetch_valid
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HAVE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_q, hold_d;
  logic        kill_q, kill_d;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_seq;

  // A stalled stage must not take a redirect; the hazard unit re-asserts it later.
  assign redirect = pc_src_d & ~stall_f;
  assign target   = pc_branch_d & ~32'h3;
  assign pc_seq   = pc_q + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_REQ;
      pc_q    <= RESET_PC;
      hold_q  <= NOP_INSTR;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      kill_q  <= kill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    kill_d  = kill_q;
    case (state_q)
      ST_REQ: begin
        if (imem_ready) begin
          state_d = ST_WAIT;
          // The request already went out for the old PC; its response must be discarded.
          if (redirect) begin
            pc_d   = target;
            kill_d = 1'b1;
          end
        end else if (redirect) begin
          pc_d = target;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          if (kill_q || redirect) begin
            kill_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            hold_d  = imem_rdata;
            state_d = ST_HAVE;
          end
          if (redirect) pc_d = target;
        end else if (redirect) begin
          pc_d   = target;
          kill_d = 1'b1;
        end
      end
      ST_HAVE: begin
        if (!stall_f) begin
          pc_d    = pc_src_d ? target : pc_seq;
          state_d = ST_REQ;
        end
      end
      default: begin
        state_d = ST_REQ;
      end
    endcase
  end

  // Gate the request with rst_n so memory never sees a request while reset is held.
  assign imem_req    = (state_q == ST_REQ) & rst_n;
  assign imem_addr   = pc_q;
  assign fetch_valid = (state_q == ST_HAVE);
  assign instr_f     = (state_q == ST_HAVE) ? hold_q : NOP_INSTR;
  assign pc_plus_4_f = pc_seq;

endmodule

// File: tb/tb_pipeline_fetch.sv
// tb/tb_pipeline_fetch.sv - table-driven bench for pipeline_fetch
module tb_pipeline_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall_f = 1'b0;
  logic        pc_src_d = 1'b0;
  logic [31:0] pc_branch_d = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr_f;
  logic [31:0] pc_plus_4_f;
  logic        fetch_valid;

  pipeline_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_f     (stall_f),
    .pc_src_d    (pc_src_d),
    .pc_branch_d (pc_branch_d),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_f     (instr_f),
    .pc_plus_4_f (pc_plus_4_f),
    .fetch_valid (fetch_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        src;
    logic [31:0] br;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input logic stall, input logic src, input logic [31:0] br,
                     input logic ready, input logic rvalid, input logic [31:0] rdata,
                     input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                     input logic [31:0] e_instr, input logic [31:0] e_pc4);
    vec_t v;
    v.stall = stall; v.src = src; v.br = br; v.ready = ready; v.rvalid = rvalid;
    v.rdata = rdata; v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_instr = e_instr; v.e_pc4 = e_pc4;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_req, input logic [31:0] e_addr,
                         input logic e_valid, input logic [31:0] e_instr, input logic [31:0] e_pc4);
    n_vec++;
    chk({tag, ".imem_req"},    {31'h0, imem_req},    {31'h0, e_req});
    chk({tag, ".imem_addr"},   imem_addr,            e_addr);
    chk({tag, ".fetch_valid"}, {31'h0, fetch_valid}, {31'h0, e_valid});
    chk({tag, ".instr_f"},     instr_f,              e_instr);
    chk({tag, ".pc_plus_4_f"}, pc_plus_4_f,          e_pc4);
  endtask

  initial begin
    //   stall src br           rdy rv rdata         req addr          v  instr         pc4
    // sequential fetch
    add(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h00400000, 0, 32'h0,        32'h00400004);
    add(0, 0, 32'h0,        0, 1, 32'h11111111, 0, 32'h00400000, 0, 32'h0,        32'h00400004);
    add(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h00400000, 1, 32'h11111111, 32'h00400004);
    add(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h00400004, 0, 32'h0,        32'h00400008);
    add(0, 0, 32'h0,        0, 1, 32'h22222222, 0, 32'h00400004, 0, 32'h0,        32'h00400008);
    // stall in HAVE for three cycles, then release
    add(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h00400004, 1, 32'h22222222, 32'h00400008);
    add(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h00400004, 1, 32'h22222222, 32'h00400008);
    add(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h00400004, 1, 32'h22222222, 32'h00400008);
    add(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h00400004, 1, 32'h22222222, 32'h00400008);
    add(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h00400008, 0, 32'h0,        32'h0040000C);
    add(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h00400008, 0, 32'h0,        32'h0040000C);
    // redirect in WAIT, response drops a cycle later
    add(0, 1, 32'h00400103, 0, 0, 32'h0,        0, 32'h00400008, 0, 32'h0,        32'h0040000C);
    add(0, 0, 32'h0,        0, 1, 32'hDEADBEEF, 0, 32'h00400100, 0, 32'h0,        32'h00400104);
    add(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h00400100, 0, 32'h0,        32'h00400104);
    add(0, 0, 32'h0,        0, 1, 32'h33333333, 0, 32'h00400100, 0, 32'h0,        32'h00400104);
    // redirect while stalled is ignored
    add(1, 1, 32'h00500000, 0, 0, 32'h0,        0, 32'h00400100, 1, 32'h33333333, 32'h00400104);
    add(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h00400100, 1, 32'h33333333, 32'h00400104);
    add(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h00400104, 0, 32'h0,        32'h00400108);
    // redirect in REQ without ready, to the wrap point
    add(0, 1, 32'hFFFFFFFC, 0, 0, 32'h0,        1, 32'h00400104, 0, 32'h0,        32'h00400108);
    add(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'hFFFFFFFC, 0, 32'h0,        32'h00000000);
    add(0, 0, 32'h0,        0, 1, 32'h44444444, 0, 32'hFFFFFFFC, 0, 32'h0,        32'h00000000);
    add(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'hFFFFFFFC, 1, 32'h44444444, 32'h00000000);
    add(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h00000000, 0, 32'h0,        32'h00000004);
    // redirect in REQ with ready: accepted request is killed
    add(0, 1, 32'h00001000, 1, 0, 32'h0,        1, 32'h00000000, 0, 32'h0,        32'h00000004);
    add(0, 0, 32'h0,        0, 1, 32'h55555555, 0, 32'h00001000, 0, 32'h0,        32'h00001004);
    add(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h00001000, 0, 32'h0,        32'h00001004);
    // redirect in WAIT coinciding with the response
    add(0, 1, 32'h00002000, 0, 1, 32'h66666666, 0, 32'h00001000, 0, 32'h0,        32'h00001004);
    add(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h00002000, 0, 32'h0,        32'h00002004);
    add(0, 0, 32'h0,        0, 1, 32'h77777777, 0, 32'h00002000, 0, 32'h0,        32'h00002004);
    // redirect in HAVE discards the held instruction
    add(0, 1, 32'h00003000, 0, 0, 32'h0,        0, 32'h00002000, 1, 32'h77777777, 32'h00002004);
    add(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h00003000, 0, 32'h0,        32'h00003004);

    #2 rst_n = 1'b0;
    #1 chk_all("reset_start", 1'b0, 32'h00400000, 1'b0, 32'h0, 32'h00400004);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      stall_f     = vecs[i].stall;
      pc_src_d    = vecs[i].src;
      pc_branch_d = vecs[i].br;
      imem_ready  = vecs[i].ready;
      imem_rvalid = vecs[i].rvalid;
      imem_rdata  = vecs[i].rdata;
      #1 chk_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
                 vecs[i].e_instr, vecs[i].e_pc4);
    end

    // last vector accepted a request at 00003000: now in WAIT, reset asynchronously mid-cycle
    @(negedge clk);
    stall_f = 1'b0; pc_src_d = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0;
    #1 chk_all("pre_reset_wait", 1'b0, 32'h00003000, 1'b0, 32'h0, 32'h00003004);
    #1 rst_n = 1'b0;
    #1 chk_all("reset_mid_wait", 1'b0, 32'h00400000, 1'b0, 32'h0, 32'h00400004);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk_all("after_reset", 1'b1, 32'h00400000, 1'b0, 32'h0, 32'h00400004);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
